// File: rtl/alarm_controller.sv
// Alarm clock controller: keeps time of day, holds an alarm setting, and runs
// the set / ring / snooze state machine. All outputs come straight from flops.
module alarm_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       one_minute,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       hour_inc,
  input  logic       min_inc,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic [4:0] time_hour,
  output logic [5:0] time_min,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       alarm_sound,
  output logic       snooze_active
);

  typedef enum logic [2:0] {
    RUN, SET_TIME, SET_ALARM, RING, SNOOZE
  } state_t;

  localparam logic [5:0] RING_LAST   = 6'd59;
  localparam logic [2:0] SNOOZE_MINS = 3'd5;

  state_t     state, next_state;
  logic [5:0] ring_cnt;
  logic [2:0] snooze_cnt;
  logic [4:0] tick_hour;
  logic [5:0] tick_min;
  logic       alarm_hit;
  logic       ring_done;
  logic       sound_d;
  logic       snooze_d;

  function automatic logic [4:0] inc_hour(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_min(input logic [5:0] m);
    return (m == 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  // Time after one minute elapses, with carry into the hour.
  always_comb begin
    tick_min  = inc_min(time_min);
    tick_hour = (time_min == 6'd59) ? inc_hour(time_hour) : time_hour;
  end

  // Match is taken on the advanced time, so setting time onto the alarm never rings.
  assign alarm_hit = one_minute && alarm_en &&
                     (tick_hour == alarm_hour) && (tick_min == alarm_min);
  assign ring_done = one_second && (ring_cnt == RING_LAST);

  // State and output register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      alarm_sound   <= 1'b0;
      snooze_active <= 1'b0;
    end else begin
      state         <= next_state;
      alarm_sound   <= sound_d;
      snooze_active <= snooze_d;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    next_state = state;
    unique case (state)
      RUN: begin
        if (alarm_hit)                   next_state = RING;
        else if (set_time && !set_alarm) next_state = SET_TIME;
        else if (set_alarm && !set_time) next_state = SET_ALARM;
      end
      SET_TIME:  if (!set_time)  next_state = RUN;
      SET_ALARM: if (!set_alarm) next_state = RUN;
      RING: begin
        if (stop || !alarm_en) next_state = RUN;
        else if (snooze)       next_state = SNOOZE;
        else if (ring_done)    next_state = RUN;
      end
      SNOOZE: begin
        if (stop || !alarm_en)                            next_state = RUN;
        else if (one_minute && (snooze_cnt == 3'd1))      next_state = RING;
      end
      default: next_state = RUN;
    endcase
  end

  // Output decode, registered above so it tracks the state being entered.
  always_comb begin
    sound_d  = (next_state == RING);
    snooze_d = (next_state == SNOOZE);
  end

  // Time, alarm setting and the ring/snooze counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      time_hour  <= 5'd0;
      time_min   <= 6'd0;
      alarm_hour <= 5'd0;
      alarm_min  <= 6'd0;
      ring_cnt   <= 6'd0;
      snooze_cnt <= 3'd0;
    end else begin
      if (state == SET_TIME) begin
        if (hour_inc) time_hour <= inc_hour(time_hour);
        if (min_inc)  time_min  <= inc_min(time_min);
      end else if (one_minute) begin
        time_hour <= tick_hour;
        time_min  <= tick_min;
      end

      if (state == SET_ALARM) begin
        if (hour_inc) alarm_hour <= inc_hour(alarm_hour);
        if (min_inc)  alarm_min  <= inc_min(alarm_min);
      end

      if ((next_state == RING) && (state != RING))
        ring_cnt <= 6'd0;
      else if ((state == RING) && one_second)
        ring_cnt <= ring_cnt + 6'd1;

      if ((next_state == SNOOZE) && (state != SNOOZE))
        snooze_cnt <= SNOOZE_MINS;
      else if ((state == SNOOZE) && one_minute)
        snooze_cnt <= snooze_cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: a behavioural model predicts the
// outputs of every clocked step; tasks drain and compare per scenario.
module tb_alarm_controller;

  logic       clock, reset;
  logic       one_second, one_minute, set_time, set_alarm;
  logic       hour_inc, min_inc, alarm_en, snooze, stop;
  logic [4:0] time_hour, alarm_hour;
  logic [5:0] time_min, alarm_min;
  logic       alarm_sound, snooze_active;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [4:0] ah;
    logic [5:0] am;
    logic       snd;
    logic       snz;
  } obs_t;

  typedef enum int {M_RUN, M_SET_TIME, M_SET_ALARM, M_RING, M_SNOOZE} m_state_t;

  m_state_t m_st;
  int       m_h, m_m, m_ah, m_am, m_rc, m_sc;
  obs_t     exp_q[$];
  obs_t     act_q[$];
  obs_t     exp_o, act_o;
  int       n_assert = 0;
  int       n_fail   = 0;

  alarm_controller dut (
    .clock        (clock),
    .reset        (reset),
    .one_second   (one_second),
    .one_minute   (one_minute),
    .set_time     (set_time),
    .set_alarm    (set_alarm),
    .hour_inc     (hour_inc),
    .min_inc      (min_inc),
    .alarm_en     (alarm_en),
    .snooze       (snooze),
    .stop         (stop),
    .time_hour    (time_hour),
    .time_min     (time_min),
    .alarm_hour   (alarm_hour),
    .alarm_min    (alarm_min),
    .alarm_sound  (alarm_sound),
    .snooze_active(snooze_active)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic obs_t observe();
    obs_t o;
    o.h = time_hour; o.m = time_min; o.ah = alarm_hour; o.am = alarm_min;
    o.snd = alarm_sound; o.snz = snooze_active;
    return o;
  endfunction

  task automatic model_reset();
    m_st = M_RUN;
    m_h = 0; m_m = 0; m_ah = 0; m_am = 0; m_rc = 0; m_sc = 0;
  endtask

  // Predict one clock edge from the currently driven inputs.
  task automatic model_step();
    int nh, nm;
    nh = m_h;
    nm = m_m;
    if (m_st != M_SET_TIME && one_minute) begin
      nm = m_m + 1;
      if (nm == 60) begin
        nm = 0;
        nh = (m_h + 1) % 24;
      end
    end
    case (m_st)
      M_RUN: begin
        if (one_minute && alarm_en && nh == m_ah && nm == m_am) begin
          m_st = M_RING; m_rc = 0;
        end else if (set_time && !set_alarm) m_st = M_SET_TIME;
        else if (set_alarm && !set_time)     m_st = M_SET_ALARM;
      end
      M_SET_TIME: begin
        if (hour_inc) nh = (m_h + 1) % 24;
        if (min_inc)  nm = (m_m + 1) % 60;
        if (!set_time) m_st = M_RUN;
      end
      M_SET_ALARM: begin
        if (hour_inc) m_ah = (m_ah + 1) % 24;
        if (min_inc)  m_am = (m_am + 1) % 60;
        if (!set_alarm) m_st = M_RUN;
      end
      M_RING: begin
        if (stop || !alarm_en) m_st = M_RUN;
        else if (snooze) begin
          m_st = M_SNOOZE; m_sc = 5;
        end else if (one_second) begin
          m_rc++;
          if (m_rc == 60) m_st = M_RUN;
        end
      end
      M_SNOOZE: begin
        if (stop || !alarm_en) m_st = M_RUN;
        else if (one_minute) begin
          m_sc--;
          if (m_sc == 0) begin
            m_st = M_RING; m_rc = 0;
          end
        end
      end
      default: m_st = M_RUN;
    endcase
    m_h = nh;
    m_m = nm;
  endtask

  // One clock: push the prediction, let the edge happen, capture the DUT, clear pulses.
  task automatic tick();
    obs_t e;
    model_step();
    e.h = 5'(m_h); e.m = 6'(m_m); e.ah = 5'(m_ah); e.am = 6'(m_am);
    e.snd = (m_st == M_RING);
    e.snz = (m_st == M_SNOOZE);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    act_q.push_back(observe());
    one_second = 0; one_minute = 0; hour_inc = 0; min_inc = 0; snooze = 0; stop = 0;
  endtask

  task automatic clear_inputs();
    one_second = 0; one_minute = 0; set_time = 0; set_alarm = 0;
    hour_inc = 0; min_inc = 0; alarm_en = 0; snooze = 0; stop = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1;
    @(posedge clock);
    #1;
    reset = 0;
    model_reset();
  endtask

  // Program alarm 06:30, time 06:29, arm, then let one minute elapse.
  task automatic setup_ringing();
    apply_reset();
    set_alarm = 1; tick();
    repeat (6)  begin hour_inc = 1; tick(); end
    repeat (30) begin min_inc  = 1; tick(); end
    set_alarm = 0; tick();
    set_time = 1; tick();
    repeat (6)  begin hour_inc = 1; tick(); end
    repeat (29) begin min_inc  = 1; tick(); end
    set_time = 0; tick();
    alarm_en = 1;
    one_minute = 1; tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    #2;
    n_assert++;
    if (observe() !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", observe(), obs_t'(0));
    end
    @(posedge clock);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_rollover();
    apply_reset();
    set_time = 1; tick();
    repeat (23) begin hour_inc = 1; tick(); end
    repeat (59) begin min_inc  = 1; tick(); end
    set_time = 0; tick();
    one_minute = 1; tick();
    while (act_q.size() > 0) begin
      exp_o = exp_q.pop_front(); act_o = act_q.pop_front(); n_assert++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL rollover_step: got %h expected %h", act_o, exp_o);
      end
    end
    n_assert++;
    if (time_hour !== 5'd0 || time_min !== 6'd0) begin
      n_fail++;
      $display("FAIL rollover_2359: got %0d:%0d expected 0:0", time_hour, time_min);
    end
  endtask

  task automatic test_set_time();
    apply_reset();
    set_time = 1; tick();
    repeat (3)  begin hour_inc = 1; tick(); end
    repeat (61) begin min_inc  = 1; tick(); end
    repeat (3)  begin one_minute = 1; tick(); end
    hour_inc = 1; min_inc = 1; tick();
    n_assert++;
    if (time_hour !== 5'd4 || time_min !== 6'd2) begin
      n_fail++;
      $display("FAIL set_time_fields: got %0d:%0d expected 4:2", time_hour, time_min);
    end
    set_time = 0; tick();
    one_minute = 1; hour_inc = 1; tick();
    while (act_q.size() > 0) begin
      exp_o = exp_q.pop_front(); act_o = act_q.pop_front(); n_assert++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL set_time_step: got %h expected %h", act_o, exp_o);
      end
    end
    n_assert++;
    if (time_hour !== 5'd4 || time_min !== 6'd3) begin
      n_fail++;
      $display("FAIL set_time_run: got %0d:%0d expected 4:3", time_hour, time_min);
    end
  endtask

  task automatic test_both_requests();
    apply_reset();
    set_time = 1; set_alarm = 1; tick();
    hour_inc = 1; min_inc = 1; tick();
    one_minute = 1; tick();
    set_time = 0; tick();
    hour_inc = 1; tick();
    set_alarm = 0; tick();
    while (act_q.size() > 0) begin
      exp_o = exp_q.pop_front(); act_o = act_q.pop_front(); n_assert++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL both_requests_step: got %h expected %h", act_o, exp_o);
      end
    end
    n_assert++;
    if (alarm_hour !== 5'd1 || time_min !== 6'd1 || time_hour !== 5'd0) begin
      n_fail++;
      $display("FAIL both_requests: got t=%0d:%0d a_h=%0d expected t=0:1 a_h=1",
               time_hour, time_min, alarm_hour);
    end
  endtask

  task automatic test_alarm_ring();
    setup_ringing();
    n_assert++;
    if (alarm_sound !== 1'b1 || time_hour !== 5'd6 || time_min !== 6'd30) begin
      n_fail++;
      $display("FAIL ring_on_match: got snd=%b t=%0d:%0d expected snd=1 t=6:30",
               alarm_sound, time_hour, time_min);
    end
    repeat (59) begin one_second = 1; tick(); end
    n_assert++;
    if (alarm_sound !== 1'b1) begin
      n_fail++;
      $display("FAIL ring_59s: got %b expected 1", alarm_sound);
    end
    one_second = 1; tick();
    n_assert++;
    if (alarm_sound !== 1'b0) begin
      n_fail++;
      $display("FAIL ring_60s: got %b expected 0", alarm_sound);
    end
    repeat (2) begin one_minute = 1; tick(); end
    while (act_q.size() > 0) begin
      exp_o = exp_q.pop_front(); act_o = act_q.pop_front(); n_assert++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL alarm_ring_step: got %h expected %h", act_o, exp_o);
      end
    end
  endtask

  task automatic test_snooze();
    setup_ringing();
    repeat (3) begin one_second = 1; tick(); end
    snooze = 1; tick();
    n_assert++;
    if (snooze_active !== 1'b1 || alarm_sound !== 1'b0) begin
      n_fail++;
      $display("FAIL snooze_enter: got snz=%b snd=%b expected snz=1 snd=0",
               snooze_active, alarm_sound);
    end
    repeat (2) begin one_minute = 1; tick(); end
    snooze = 1; set_time = 1; tick();
    set_time = 0;
    repeat (2) begin one_minute = 1; tick(); end
    n_assert++;
    if (alarm_sound !== 1'b0 || snooze_active !== 1'b1) begin
      n_fail++;
      $display("FAIL snooze_4min: got snd=%b snz=%b expected snd=0 snz=1",
               alarm_sound, snooze_active);
    end
    one_minute = 1; tick();
    n_assert++;
    if (alarm_sound !== 1'b1 || snooze_active !== 1'b0) begin
      n_fail++;
      $display("FAIL snooze_5min: got snd=%b snz=%b expected snd=1 snz=0",
               alarm_sound, snooze_active);
    end
    repeat (59) begin one_second = 1; tick(); end
    snooze = 1; tick();
    alarm_en = 0; tick();
    while (act_q.size() > 0) begin
      exp_o = exp_q.pop_front(); act_o = act_q.pop_front(); n_assert++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL snooze_step: got %h expected %h", act_o, exp_o);
      end
    end
  endtask

  task automatic test_stop_and_snooze();
    setup_ringing();
    stop = 1; snooze = 1; tick();
    n_assert++;
    if (alarm_sound !== 1'b0 || snooze_active !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_beats_snooze: got snd=%b snz=%b expected 0 0",
               alarm_sound, snooze_active);
    end
    repeat (3) begin one_minute = 1; tick(); end
    while (act_q.size() > 0) begin
      exp_o = exp_q.pop_front(); act_o = act_q.pop_front(); n_assert++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL stop_snooze_step: got %h expected %h", act_o, exp_o);
      end
    end
  endtask

  task automatic test_async_reset();
    setup_ringing();
    snooze = 1; tick();
    one_minute = 1; tick();
    while (act_q.size() > 0) begin
      exp_o = exp_q.pop_front(); act_o = act_q.pop_front(); n_assert++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL async_reset_pre: got %h expected %h", act_o, exp_o);
      end
    end
    @(negedge clock);
    reset = 1;
    #1;
    n_assert++;
    if (observe() !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL async_reset_mid_snooze: got %h expected %h", observe(), obs_t'(0));
    end
    @(posedge clock);
    #1;
    reset = 0;
    model_reset();
    clear_inputs();
    one_minute = 1; tick();
    while (act_q.size() > 0) begin
      exp_o = exp_q.pop_front(); act_o = act_q.pop_front(); n_assert++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL async_reset_resume: got %h expected %h", act_o, exp_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_set_time();
    test_both_requests();
    test_alarm_ring();
    test_snooze();
    test_stop_and_snooze();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
